// File: rtl/axis_stream_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : axis_stream_scoreboard
// Purpose  : Passive AXI4-Stream scoreboard. Taps an expected (reference)
//            stream and an actual (DUT output) stream, buffers expected beats
//            in a FIFO and compares every actual beat against the FIFO head.
//            Counts beats, packets and mismatches, and reports done/pass once
//            the programmed number of actual packets has been checked.
// Optional : define SCB_FIRST_ERR_CAPTURE_EN to add first-error capture ports
//            (first_err_idx, first_err_exp, first_err_act).
// Ports    : aclk, aresetn         - clock, async active-low reset
//            start, pkt_target     - arm a run / number of packets to check
//            exp_t* / act_t*       - passive taps of both streams (inputs only)
//            busy, done, pass      - run status
//            mismatch              - one-cycle pulse per failed compare
//            beat_cnt, err_cnt     - saturating beat / error counters
//            pkt_cnt               - actual packets completed
//            overflow, underflow   - sticky FIFO error flags
// Revision : 1.0 - initial release
// ============================================================================
module axis_stream_scoreboard #(
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 16,
    parameter  int CNT_W  = 32,
    localparam int KEEP_W = DATA_W / 8
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              start,
    input  logic [15:0]       pkt_target,
    input  logic              exp_tvalid,
    input  logic              exp_tready,
    input  logic [DATA_W-1:0] exp_tdata,
    input  logic [KEEP_W-1:0] exp_tkeep,
    input  logic              exp_tlast,
    input  logic              act_tvalid,
    input  logic              act_tready,
    input  logic [DATA_W-1:0] act_tdata,
    input  logic [KEEP_W-1:0] act_tkeep,
    input  logic              act_tlast,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              mismatch,
    output logic [CNT_W-1:0]  beat_cnt,
    output logic [CNT_W-1:0]  err_cnt,
    output logic [15:0]       pkt_cnt,
    output logic              overflow,
    output logic              underflow
`ifdef SCB_FIRST_ERR_CAPTURE_EN
    ,
    output logic [CNT_W-1:0]  first_err_idx,
    output logic [DATA_W-1:0] first_err_exp,
    output logic [DATA_W-1:0] first_err_act
`endif
);

    localparam int               c_AW      = $clog2(DEPTH);
    localparam int               c_ENTRY_W = DATA_W + KEEP_W + 1;
    localparam logic [c_AW:0]    c_PTR_ONE = {{c_AW{1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              r_state;
    logic                r_busy;
    logic                r_done;
    logic                r_mismatch;
    logic [CNT_W-1:0]    r_beat_cnt;
    logic [CNT_W-1:0]    r_err_cnt;
    logic [15:0]         r_pkt_cnt;
    logic [15:0]         r_target;
    logic                r_overflow;
    logic                r_underflow;
    logic [c_AW:0]       r_wr_ptr;
    logic [c_AW:0]       r_rd_ptr;
    logic [c_ENTRY_W-1:0] r_mem [DEPTH];

    logic                w_run;
    logic                w_start_run;
    logic                w_exp_beat;
    logic                w_act_beat;
    logic                w_empty;
    logic                w_full;
    logic [c_ENTRY_W-1:0] w_head;
    logic                w_bypass;
    logic                w_pop;
    logic                w_push;
    logic                w_ovf_evt;
    logic                w_unf_evt;
    logic [DATA_W-1:0]   w_ref_data;
    logic [KEEP_W-1:0]   w_ref_keep;
    logic                w_ref_last;
    logic [KEEP_W-1:0]   w_byte_ok;
    logic                w_cmp_ok;
    logic                w_fail;

    assign w_run       = (r_state == ST_RUN);
    // start is honoured only outside RUN
    assign w_start_run = start && (r_state != ST_RUN);
    assign w_exp_beat  = exp_tvalid && exp_tready;
    assign w_act_beat  = act_tvalid && act_tready;

    // Extra pointer MSB distinguishes full from empty when the indices match
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                     (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign w_head  = r_mem[r_rd_ptr[c_AW-1:0]];

    // Empty FIFO with beats on both streams: compare straight through, store nothing
    assign w_bypass  = w_run && w_act_beat && w_empty && w_exp_beat;
    assign w_pop     = w_run && w_act_beat && !w_empty;
    // A full FIFO still accepts a push when the same cycle frees a slot
    assign w_push    = w_run && w_exp_beat && !w_bypass && (!w_full || w_pop);
    assign w_ovf_evt = w_run && w_exp_beat && w_full && !w_pop;
    assign w_unf_evt = w_run && w_act_beat && w_empty && !w_exp_beat;

    // Reference beat: incoming expected beat when bypassing, else FIFO head
    always_comb begin
        w_ref_data = w_head[c_ENTRY_W-1 -: DATA_W];
        w_ref_keep = w_head[KEEP_W:1];
        w_ref_last = w_head[0];
        if (w_empty) begin
            w_ref_data = exp_tdata;
            w_ref_keep = exp_tkeep;
            w_ref_last = exp_tlast;
        end
    end

    // Bytes disabled by the expected keep are don't-care
    for (genvar gi = 0; gi < KEEP_W; gi++) begin : g_byte
        assign w_byte_ok[gi] = !w_ref_keep[gi] ||
                               (w_ref_data[gi*8 +: 8] == act_tdata[gi*8 +: 8]);
    end

    assign w_cmp_ok = (w_ref_keep == act_tkeep) && (w_ref_last == act_tlast) && (&w_byte_ok);
    assign w_fail   = w_run && w_act_beat && (w_unf_evt || !w_cmp_ok);

    // FIFO storage (no reset needed; validity is tracked by the pointers)
    always_ff @(posedge aclk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[c_AW-1:0]] <= {exp_tdata, exp_tkeep, exp_tlast};
        end
    end

    // Control FSM, counters, flags and pointers
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state     <= ST_IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_mismatch  <= 1'b0;
            r_beat_cnt  <= '0;
            r_err_cnt   <= '0;
            r_pkt_cnt   <= '0;
            r_target    <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
        end else begin
            r_mismatch <= 1'b0;
            case (r_state)
                ST_RUN: begin
                    if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
                    if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
                    if (w_ovf_evt) r_overflow  <= 1'b1;
                    if (w_unf_evt) r_underflow <= 1'b1;
                    if (w_act_beat) begin
                        if (r_beat_cnt != c_CNT_MAX) r_beat_cnt <= r_beat_cnt + c_CNT_ONE;
                        if (w_fail && (r_err_cnt != c_CNT_MAX)) r_err_cnt <= r_err_cnt + c_CNT_ONE;
                        if (act_tlast) r_pkt_cnt <= r_pkt_cnt + 16'd1;
                        r_mismatch <= w_fail;
                    end
                    // Reacts to the registered count, so DONE follows one cycle later
                    if (r_pkt_cnt >= r_target) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    if (w_start_run) begin
                        r_state     <= ST_RUN;
                        r_busy      <= 1'b1;
                        r_done      <= 1'b0;
                        r_beat_cnt  <= '0;
                        r_err_cnt   <= '0;
                        r_pkt_cnt   <= '0;
                        r_target    <= pkt_target;
                        r_overflow  <= 1'b0;
                        r_underflow <= 1'b0;
                        r_wr_ptr    <= '0;
                        r_rd_ptr    <= '0;
                    end
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign mismatch  = r_mismatch;
    assign beat_cnt  = r_beat_cnt;
    assign err_cnt   = r_err_cnt;
    assign pkt_cnt   = r_pkt_cnt;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;
    // Leftover expected beats also fail the run
    assign pass      = r_done && (r_err_cnt == '0) && !r_overflow && !r_underflow && w_empty;

`ifdef SCB_FIRST_ERR_CAPTURE_EN
    logic [CNT_W-1:0]  r_first_err_idx;
    logic [DATA_W-1:0] r_first_err_exp;
    logic [DATA_W-1:0] r_first_err_act;

    // Captured in the cycle whose compare takes err_cnt from 0 to 1
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_first_err_idx <= '0;
            r_first_err_exp <= '0;
            r_first_err_act <= '0;
        end else if (w_start_run) begin
            r_first_err_idx <= '0;
            r_first_err_exp <= '0;
            r_first_err_act <= '0;
        end else if (w_fail && (r_err_cnt == '0)) begin
            r_first_err_idx <= r_beat_cnt;
            r_first_err_exp <= w_unf_evt ? '0 : w_ref_data;
            r_first_err_act <= act_tdata;
        end
    end

    assign first_err_idx = r_first_err_idx;
    assign first_err_exp = r_first_err_exp;
    assign first_err_act = r_first_err_act;
`endif

endmodule
`default_nettype wire

// File: doc/axis_stream_scoreboard.md
Name: axis_stream_scoreboard

Overview:
- Synthesizable AXI4-Stream scoreboard that passively taps two streams: an expected (reference) stream and an actual (DUT output) stream.
- Buffers expected beats in an internal FIFO and compares each accepted actual beat against the FIFO head.
- Counts beats, packets and mismatches, and raises done/pass once a programmed number of packets has been checked.
- Sits next to the VIP master/slave pair in the `chip` block design, so self-checking runs in hardware or in simulation without a testbench queue.

Parameters:
- DATA_W, 32, tdata width in bits; must be a multiple of 8.
- KEEP_W, DATA_W/8, tkeep width (derived, not overridden).
- DEPTH, 16, expected-beat FIFO depth; power of 2, minimum 2.
- CNT_W, 32, width of the beat and error counters.

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; clears state and arms a check run
- pkt_target  in  16  number of actual packets (tlast) to check, sampled on start
- exp_tvalid / exp_tready  in  1 each  expected-stream handshake tap
- exp_tdata  in  DATA_W  expected-stream data tap
- exp_tkeep  in  KEEP_W  expected-stream byte enables tap
- exp_tlast  in  1  expected-stream end-of-packet tap
- act_tvalid / act_tready / act_tdata / act_tkeep / act_tlast  in  same widths  actual-stream taps
- busy  out  1  high in RUN
- done  out  1  high in DONE
- pass  out  1  valid while done; 1 = clean run
- mismatch  out  1  one-cycle pulse per failed beat compare
- beat_cnt  out  CNT_W  actual beats compared
- err_cnt  out  CNT_W  failed beat compares
- pkt_cnt  out  16  actual packets completed
- overflow  out  1  sticky; expected beat dropped because FIFO was full
- underflow  out  1  sticky; actual beat arrived with no expected beat available

Behaviour:
- Reset values: all outputs 0, state IDLE, FIFO empty. Reset mid-run aborts immediately with the same values.
- Beat definition: a beat occurs when tvalid && tready on that stream. The block never drives tready.
- IDLE:
  - Beats on both streams are ignored.
  - start → clear counters, sticky flags and FIFO; latch pkt_target; go to RUN.
- RUN:
  - Expected beat pushes {tdata, tkeep, tlast} into the FIFO.
  - Actual beat pops the FIFO head and compares against it.
  - Simultaneous push and pop are legal when the FIFO is full (no overflow) and when it is empty.
  - Empty-FIFO bypass: if the FIFO is empty and both beats occur in the same cycle, the actual beat is compared directly against the incoming expected beat, and nothing is stored.
  - Empty FIFO with no same-cycle expected beat → set underflow; beat_cnt++; err_cnt++; mismatch pulses.
  - Full FIFO with an expected beat and no same-cycle pop → set overflow; the beat is dropped.
- Compare rule: pass only if all three hold:
  - tkeep matches exactly;
  - tlast matches;
  - every tdata byte whose expected tkeep bit is 1 matches.
  - Bytes with tkeep 0 are don't-care.
- Latency: compare is registered. For an actual beat in cycle N, beat_cnt, err_cnt, mismatch and pkt_cnt update in cycle N+1.
- pkt_cnt increments on every actual beat with tlast=1, whether or not it mismatched.
- RUN → DONE on the cycle after pkt_cnt reaches the latched target. start while in RUN is ignored.
- pkt_target = 0: enter RUN, then DONE on the next cycle.
- DONE:
  - Counters freeze; further beats are ignored.
  - pass = (err_cnt==0) && !overflow && !underflow && FIFO empty. Leftover expected beats make pass 0.
  - start → new run, same as from IDLE.
- Counter saturation: beat_cnt and err_cnt saturate at all-ones and never wrap.
- FIFO pointers: log2(DEPTH)+1 bits; full/empty derived from the MSB and the remaining bits.

Optional Feature:
- Macro: SCB_FIRST_ERR_CAPTURE_EN.
- When defined, three extra outputs are added:
  - first_err_idx [CNT_W]: beat_cnt value of the first failing beat;
  - first_err_exp [DATA_W]: expected tdata of that beat;
  - first_err_act [DATA_W]: actual tdata of that beat.
- These are captured once per run, written in the same cycle err_cnt first becomes 1, cleared by start and by reset, and held afterwards.
- An underflow capture records first_err_exp = 0.
- When undefined, these ports and their registers do not exist.

Test Plan:
- Basic match: DATA_W=32, start with pkt_target=5; 5 identical 4-beat packets on both streams, actual lagging 3 cycles → done=1, pass=1, beat_cnt=20, err_cnt=0, pkt_cnt=5.
- Data corruption: actual beat 2 of packet 1 tdata=0xDEADBEEF vs expected 0xDEADBEEE → one mismatch pulse, err_cnt=1, pass=0. With SCB_FIRST_ERR_CAPTURE_EN: first_err_idx=6, exp=0xDEADBEEE, act=0xDEADBEEF.
- Keep masking: expected and actual tkeep=4'b0011, data differ only in bytes 2–3 → err_cnt=0. Change actual tkeep to 4'b0111 → err_cnt=1.
- Full/overflow: DEPTH=4; 5 expected beats, no actual beats → overflow=1. Then a simultaneous push/pop while full → no further overflow, and FIFO occupancy stays 4.
- Underflow and bypass: an actual beat with the FIFO empty and no expected beat → underflow=1, err_cnt=1. A same-cycle matching beat on both streams with the FIFO empty → err_cnt unchanged.
- Restart/reset: pkt_target=0 → DONE one cycle after RUN with pass=1. Assert aresetn low mid-run → all outputs 0. A new start after DONE → counters cleared.
